// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared definitions for the 4-bit loadable counter and the
//            serial load sequencer that feeds it.
// Contents : CNT_WIDTH        - counter / data word width
//            DEFAULT_TIMEOUT  - default idle-cycle limit while shifting
//            TMO_W            - width of the timeout counter (limit <= 255)
//            seq_state_t      - load sequencer state encoding
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int CNT_WIDTH       = 4;
  localparam int DEFAULT_TIMEOUT = 15;
  localparam int TMO_W           = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SETUP  = 3'd2,
    LOAD   = 3'd3,
    VERIFY = 3'd4
  } seq_state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/ser_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : ser_shift_reg
// Purpose  : WIDTH-bit MSB-first serial-to-parallel shift register with a
//            synchronous clear, a shift enable and a bit counter.
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous active-low reset
//            i_clear      - clear word and bit count (has priority)
//            i_shift      - shift i_bit in this cycle
//            i_bit        - serial data bit
//            o_word_next  - word as it will be after shifting i_bit in
//            o_last       - this shift completes the WIDTH-bit word
// Revision : 1.0 - initial release
// ============================================================================
module ser_shift_reg
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_word_next,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_count;

  // Look-ahead word lets the parent capture the full word on the same edge
  // that accepts the final bit.
  assign o_word_next = {r_word[WIDTH-2:0], i_bit};
  assign o_last      = i_shift && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_word  <= o_word_next;
      r_count <= r_count + CW'(1);
    end
  end

endmodule : ser_shift_reg
`default_nettype wire

// File: rtl/load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : load_sequencer
// Purpose  : Assembles a framed MSB-first serial word, presents it to the
//            loadable counter with one cycle of setup, pulses load, then
//            checks the counter's feedback value on the following cycle.
// Ports    : clk        - rising-edge clock (shared with the counter)
//            reset      - asynchronous active-low reset
//            start      - frame start request, honoured only when idle
//            ser_valid  - ser_in carries a bit this cycle
//            ser_in     - serial data bit, MSB first
//            cnt_in     - counter's current value
//            load       - one-cycle load strobe to the counter
//            data       - parallel word to the counter
//            busy       - high whenever a frame is in progress
//            done       - one-cycle pulse: counter took the word
//            err        - one-cycle pulse: bit timeout or verify mismatch
// Revision : 1.0 - initial release
// ============================================================================
module load_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             load,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  seq_state_t       r_state, w_state_next;
  logic [TMO_W-1:0] r_tmo,   w_tmo_next;
  logic [WIDTH-1:0] r_data,  w_data_next;
  logic             r_load,  w_load_next;
  logic             r_busy,  w_busy_next;
  logic             r_done,  w_done_next;
  logic             r_err,   w_err_next;

  logic             w_sr_clear;
  logic             w_sr_shift;
  logic             w_sr_last;
  logic [WIDTH-1:0] w_sr_word;

  // Bits are only accepted while shifting, so a bit arriving together with
  // start in IDLE is dropped.
  assign w_sr_clear = (r_state == IDLE) && start;
  assign w_sr_shift = (r_state == SHIFT) && ser_valid;

  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_sr_clear),
    .i_shift     (w_sr_shift),
    .i_bit       (ser_in),
    .o_word_next (w_sr_word),
    .o_last      (w_sr_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_tmo_next   = r_tmo;
    w_data_next  = r_data;
    w_load_next  = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = SHIFT;
          w_tmo_next   = '0;
        end
      end

      SHIFT: begin
        if (ser_valid) begin
          w_tmo_next = '0;
          if (w_sr_last) begin
            w_data_next  = w_sr_word;
            w_state_next = SETUP;
          end
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th in a row: abandon the frame.
          w_tmo_next   = '0;
          w_err_next   = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_tmo_next = r_tmo + TMO_W'(1);
        end
      end

      SETUP: begin
        // Registered load rises as we enter LOAD.
        w_load_next  = 1'b1;
        w_state_next = LOAD;
      end

      LOAD: begin
        w_state_next = VERIFY;
      end

      VERIFY: begin
        // Counter captured on the edge that ended LOAD; it must match now.
        if (cnt_in == r_data) begin
          w_done_next = 1'b1;
        end else begin
          w_err_next = 1'b1;
        end
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tmo   <= '0;
      r_data  <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tmo   <= w_tmo_next;
      r_data  <= w_data_next;
      r_load  <= w_load_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign load = r_load;
  assign data = r_data;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule : load_sequencer
`default_nettype wire

// File: tb/tb_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_sequencer
// Purpose  : Bench for load_sequencer driving a simple loadable up-counter
//            whose value is fed back as cnt_in. A frame-level reference
//            model predicts every output each cycle; directed frames add
//            literal expectations, then a randomized run follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_sequencer;

  localparam int W   = 4;
  localparam int TMO = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         ser_valid = 1'b0;
  logic         ser_in = 1'b0;
  logic         force_zero = 1'b0;
  logic [W-1:0] r_cnt;
  logic [W-1:0] cnt_in;
  logic         load, busy, done, err;
  logic [W-1:0] data;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  load_sequencer #(
    .WIDTH   (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ser_valid (ser_valid),
    .ser_in    (ser_in),
    .cnt_in    (cnt_in),
    .load      (load),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // The counter being fed: free-running up-counter with parallel load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_cnt <= '0;
    else if (load) r_cnt <= data;
    else           r_cnt <= r_cnt + 4'd1;
  end
  assign cnt_in = force_zero ? '0 : r_cnt;

  // ---------------- frame-level reference model ----------------
  bit           m_active = 1'b0;
  int           m_nbits  = 0;
  int           m_gap    = 0;
  int           m_after  = 0;   // edges since word completed, 0 = still shifting
  logic [W-1:0] m_word   = '0;
  logic         e_load = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [W-1:0] e_data = '0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_active = 1'b0; m_nbits = 0; m_gap = 0; m_after = 0; m_word = '0;
      e_load = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_data = '0;
    end else begin
      e_load = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1; m_nbits = 0; m_gap = 0; m_after = 0; m_word = '0;
        end
      end else if (m_after == 0) begin
        if (ser_valid) begin
          m_word  = (m_word << 1) | W'(ser_in);
          m_nbits = m_nbits + 1;
          m_gap   = 0;
          if (m_nbits == W) begin
            e_data  = m_word;
            m_after = 1;
          end
        end else begin
          m_gap = m_gap + 1;
          if (m_gap == TMO) begin
            e_err    = 1'b1;
            m_active = 1'b0;
          end
        end
      end else begin
        m_after = m_after + 1;
        if (m_after == 2) begin
          e_load = 1'b1;
        end else if (m_after == 4) begin
          if (cnt_in == e_data) e_done = 1'b1;
          else                  e_err  = 1'b1;
          m_active = 1'b0;
        end
      end
      e_busy = m_active;
    end
  end

  task automatic cmp1(input string nm, input logic act, input logic exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic cmpw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (reset && chk_en) begin
      cmp1("load", load, e_load);
      cmp1("busy", busy, e_busy);
      cmp1("done", done, e_done);
      cmp1("err",  err,  e_err);
      cmpw("data", data, e_data);
      cmp1("done_err_excl", done & err, 1'b0);
    end
  end

  // Present inputs for one rising edge, return at the next falling edge.
  task automatic drive(input logic s, input logic v, input logic b);
    start = s; ser_valid = v; ser_in = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int gap);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      drive(1'b0, 1'b1, w[i]);
      if (i > 0) repeat (gap) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset held with clock running
    repeat (3) @(negedge clk);
    cmp1("rst_load", load, 1'b0);
    cmpw("rst_data", data, 4'b0000);
    cmp1("rst_busy", busy, 1'b0);
    cmp1("rst_done", done, 1'b0);
    cmp1("rst_err",  err,  1'b0);
    reset  = 1'b1;
    chk_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Nominal frame 1011
    send_frame(4'b1011, 0);
    cmpw("nom_data", data, 4'b1011);
    cmp1("nom_noload", load, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("nom_load", load, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("nom_load_off", load, 1'b0);
    cmpw("nom_counter", r_cnt, 4'b1011);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("nom_done", done, 1'b1);
    cmp1("nom_idle", busy, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("nom_done_off", done, 1'b0);

    // Timeout after the 2nd bit
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    repeat (TMO - 1) drive(1'b0, 1'b0, 1'b0);
    cmp1("tmo_not_yet", err, 1'b0);
    cmp1("tmo_busy", busy, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("tmo_err", err, 1'b1);
    cmp1("tmo_idle", busy, 1'b0);
    cmpw("tmo_data_kept", data, 4'b1011);
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    // Gapped bits 0111, 3 idle cycles between bits
    send_frame(4'b0111, 3);
    cmpw("gap_data", data, 4'b0111);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    cmp1("gap_done", done, 1'b1);

    // Verify mismatch: counter feedback forced to zero during VERIFY
    send_frame(4'b1100, 0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    force_zero = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    force_zero = 1'b0;
    cmp1("mis_err", err, 1'b1);
    cmp1("mis_done", done, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Reset mid-SHIFT clears data without a clock edge
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1;
    cmpw("arst_data", data, 4'b0000);
    cmp1("arst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // start ignored while busy (during SHIFT, SETUP and LOAD)
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("busy_start_done", done, 1'b1);
    cmpw("busy_start_data", data, 4'b0110);

    // start together with ser_valid in IDLE: that bit is dropped
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    cmpw("sim_data", data, 4'b0100);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    cmp1("sim_done", done, 1'b1);

    // Back-to-back frames 1111 then 0000
    send_frame(4'b1111, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    cmpw("b2b_cnt1", r_cnt, 4'b1111);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("b2b_done1", done, 1'b1);
    send_frame(4'b0000, 0);
    repeat (2) drive(1'b0, 1'b0, 1'b0);
    cmpw("b2b_cnt2", r_cnt, 4'b0000);
    drive(1'b0, 1'b0, 1'b0);
    cmp1("b2b_done2", done, 1'b1);

    // Randomized traffic with varying bit density
    for (int seg = 0; seg < 12; seg++) begin
      int p;
      case ($urandom_range(0, 2))
        0:       p = 2;
        1:       p = 10;
        default: p = 20;
      endcase
      repeat (250) begin
        force_zero = ($urandom_range(0, 9) == 0);
        drive($urandom_range(0, 7) == 0, $urandom_range(0, p - 1) == 0,
              1'($urandom_range(0, 1)));
      end
    end
    force_zero = 1'b0;
    repeat (20) drive(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_load_sequencer
`default_nettype wire
